serial_frame_tx: RTL

//  Parallel-to-serial frame transmitter: accepts a WIDTH-bit word via valid/ready handshake
//  and drives it onto the 1-bit line `out`, one bit per clk.

---
 rtl/serial_frame_tx_pkg.sv | 17 +
 rtl/serial_frame_tx_piso_shift.sv | 28 ++
 rtl/serial_frame_tx.sv | 95 +++++++++
 3 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter.
// The receiver reuses these state encodings and line levels.
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_piso_shift.sv
// Parallel-in serial-out register: load a word, shift right, LSB is the serial bit.
module serial_frame_tx_piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out
);

  logic [WIDTH-1:0] shreg;

  // Load has priority so a new word is never corrupted by a stale shift request.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

  assign bit_out = shreg[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Frame transmitter: start bit, data LSB first, optional even parity, stop bit.
// The line bit is registered from the next state, so it lines up with the FSM state.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  tx_state_e state, next_state;
  logic [CW-1:0] bit_cnt;
  logic parity;
  logic data_bit;
  logic accept;
  logic load;
  logic shift;
  logic out_next;

  serial_frame_tx_piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (in_data),
    .bit_out   (data_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_START;
      ST_START:  next_state = ST_DATA;
      ST_DATA:   if (bit_cnt == LAST_BIT) next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: next_state = ST_STOP;
      ST_STOP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // A data bit is consumed on every edge that enters or stays in DATA.
  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
    tx_done  = (state == ST_STOP);
    accept   = in_valid && in_ready;
    load     = accept;
    shift    = (next_state == ST_DATA);
    out_next = IDLE_LEVEL;
    case (next_state)
      ST_IDLE:   out_next = IDLE_LEVEL;
      ST_START:  out_next = START_LEVEL;
      ST_DATA:   out_next = data_bit;
      ST_PARITY: out_next = parity;
      ST_STOP:   out_next = STOP_LEVEL;
      default:   out_next = IDLE_LEVEL;
    endcase
  end

  // Counter holds on the last data bit; parity already covers every bit by then.
  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= IDLE_LEVEL;
      bit_cnt <= '0;
      parity  <= 1'b0;
    end else begin
      out <= out_next;
      if (load) begin
        bit_cnt <= '0;
        parity  <= 1'b0;
      end else if (shift) begin
        parity <= parity ^ data_bit;
        if (state == ST_DATA) bit_cnt <= bit_cnt + CW'(1);
        else                  bit_cnt <= '0;
      end
    end
  end

endmodule
